audio_dac_serializer: RTL and testbench

- Playback-side counterpart of the audio filter path. Accepts 24-bit signed stereo samples through a write/write_ready handshake and buffers them in a stereo FIFO.
- Serializes each sample MSB-first onto the codec DAC data line in I2S format.
- Codec bit clock and LR clock are external, asynchronous inputs. They are synchronized and edge-detected in the clk domain.
- Sits between the filter output (nrd_left/nrd_right) and the codec DACDAT pin.

---
 rtl/audio_dac_serializer.sv | 186 ++++++++++++++++++
 tb/tb_audio_dac_serializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_serializer.sv
`default_nettype none
// ============================================================================
// Module   : audio_dac_serializer
// Brief    : Stereo FIFO feeding an I2S DAC serializer clocked by external BCLK/LRCK.
// Revision : 1.0
// ============================================================================
module audio_dac_serializer #(
  parameter int WIDTH      = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bclk_in,
  input  logic                          daclrck_in,
  input  logic                          write,
  input  logic [WIDTH-1:0]              writedata_left,
  input  logic [WIDTH-1:0]              writedata_right,
  output logic                          write_ready,
  output logic                          dacdat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_cw = $clog2(WIDTH + 1);
  localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(FIFO_DEPTH);
  localparam logic [c_cw-1:0] c_width = c_cw'(WIDTH);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_left  = 2'd1;
  localparam logic [1:0] c_st_right = 2'd2;
  localparam logic [1:0] c_st_pad   = 2'd3;

  logic r_bclk_s1, r_bclk_s2, r_bclk_h;
  logic r_lrck_s1, r_lrck_s2;
  logic r_lrck_cur, r_lrck_prev;
  logic w_rise, w_fall, w_left_start, w_right_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bclk_s1   <= 1'b0;
      r_bclk_s2   <= 1'b0;
      r_bclk_h    <= 1'b0;
      r_lrck_s1   <= 1'b0;
      r_lrck_s2   <= 1'b0;
      r_lrck_cur  <= 1'b0;
      r_lrck_prev <= 1'b0;
    end else begin
      r_bclk_s1 <= bclk_in;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_h  <= r_bclk_s2;
      r_lrck_s1 <= daclrck_in;
      r_lrck_s2 <= r_lrck_s1;
      if (w_rise) begin
        r_lrck_cur  <= r_lrck_s2;
        r_lrck_prev <= r_lrck_cur;
      end
    end
  end

  // Boundaries are acted on at the fall after LRCK was captured, giving the I2S one-bit delay.
  assign w_rise        = r_bclk_s2 & ~r_bclk_h;
  assign w_fall        = ~r_bclk_s2 & r_bclk_h;
  assign w_left_start  = w_fall & r_lrck_prev & ~r_lrck_cur;
  assign w_right_start = w_fall & ~r_lrck_prev & r_lrck_cur;

  logic [WIDTH-1:0] r_mem_l [FIFO_DEPTH];
  logic [WIDTH-1:0] r_mem_r [FIFO_DEPTH];
  logic [c_aw-1:0]  r_wr_ptr, r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_empty, w_full, w_push, w_pop;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_depth);
  assign w_push      = write & ~w_full;
  assign w_pop       = w_left_start & ~w_empty;
  assign write_ready = ~w_full;
  assign fifo_level  = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_l[r_wr_ptr] <= writedata_left;
      r_mem_r[r_wr_ptr] <= writedata_right;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  logic [1:0]       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift_l, r_shift_r, w_shift_l_nxt, w_shift_r_nxt;
  logic [WIDTH-1:0] w_load_l, w_load_r;
  logic [c_cw-1:0]  r_bitcnt, w_bitcnt_nxt;
  logic             r_dacdat, w_dacdat_nxt;
  logic             r_underflow, w_underflow_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_st_idle;
      r_shift_l   <= '0;
      r_shift_r   <= '0;
      r_bitcnt    <= '0;
      r_dacdat    <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift_l   <= w_shift_l_nxt;
      r_shift_r   <= w_shift_r_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_dacdat    <= w_dacdat_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_left_start)
      w_state_nxt = c_st_left;
    else if (w_right_start && (r_state == c_st_left || r_state == c_st_pad))
      w_state_nxt = c_st_right;
    else if (w_fall && (r_state == c_st_left || r_state == c_st_right) && r_bitcnt == c_width)
      w_state_nxt = c_st_pad;
  end

  // Shift registers hold the bits still to be sent, so the MSB is consumed at load time.
  always_comb begin
    w_load_l        = w_empty ? '0 : r_mem_l[r_rd_ptr];
    w_load_r        = w_empty ? '0 : r_mem_r[r_rd_ptr];
    w_shift_l_nxt   = r_shift_l;
    w_shift_r_nxt   = r_shift_r;
    w_bitcnt_nxt    = r_bitcnt;
    w_dacdat_nxt    = r_dacdat;
    w_underflow_nxt = 1'b0;
    if (w_left_start) begin
      w_dacdat_nxt    = w_load_l[WIDTH-1];
      w_shift_l_nxt   = w_load_l << 1;
      w_shift_r_nxt   = w_load_r;
      w_bitcnt_nxt    = c_cw'(1);
      w_underflow_nxt = w_empty;
    end else if (w_right_start && (r_state == c_st_left || r_state == c_st_pad)) begin
      w_dacdat_nxt  = r_shift_r[WIDTH-1];
      w_shift_r_nxt = r_shift_r << 1;
      w_bitcnt_nxt  = c_cw'(1);
    end else if (w_fall) begin
      case (r_state)
        c_st_left: begin
          if (r_bitcnt == c_width) begin
            w_dacdat_nxt = 1'b0;
          end else begin
            w_dacdat_nxt  = r_shift_l[WIDTH-1];
            w_shift_l_nxt = r_shift_l << 1;
            w_bitcnt_nxt  = r_bitcnt + 1'b1;
          end
        end
        c_st_right: begin
          if (r_bitcnt == c_width) begin
            w_dacdat_nxt = 1'b0;
          end else begin
            w_dacdat_nxt  = r_shift_r[WIDTH-1];
            w_shift_r_nxt = r_shift_r << 1;
            w_bitcnt_nxt  = r_bitcnt + 1'b1;
          end
        end
        default: w_dacdat_nxt = 1'b0;
      endcase
    end
  end

  assign dacdat    = r_dacdat;
  assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_audio_dac_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_dac_serializer
// Brief    : Randomized self-checking bench with a per-bit I2S reference model.
// Revision : 1.0
// ============================================================================
module tb_audio_dac_serializer;

  localparam int W = 24;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset, bclk, lrck, write;
  logic [W-1:0] wl, wr;
  logic         write_ready, dacdat, underflow;
  logic [3:0]   fifo_level;

  audio_dac_serializer #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .bclk_in(bclk), .daclrck_in(lrck),
    .write(write), .writedata_left(wl), .writedata_right(wr),
    .write_ready(write_ready), .dacdat(dacdat),
    .fifo_level(fifo_level), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: queued pairs plus per-channel state; bit f after a channel's LRCK edge.
  logic [W-1:0] q_l[$];
  logic [W-1:0] q_r[$];
  bit           m_active = 1'b0;
  logic [W-1:0] m_pend_r = '0;
  logic         m_tail   = 1'b0;

  function automatic logic bit_at(input logic [W-1:0] s, input int f);
    if (f >= 1 && f <= W) return s[W-f];
    return 1'b0;
  endfunction

  task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
    @(negedge clk);
    check_eq("wr_ready", {31'd0, write_ready}, {31'd0, (q_l.size() < D)});
    write = 1'b1; wl = l; wr = r;
    @(negedge clk);
    write = 1'b0;
    if (q_l.size() < D) begin
      q_l.push_back(l);
      q_r.push_back(r);
    end
    check_eq("level_push", {28'd0, fifo_level}, q_l.size());
  endtask

  task automatic run_half(input bit is_right, input int n, input int rst_at, input bit wr_at_pop);
    logic [W-1:0] s, y;
    bit act, exp_uf;
    int uf;
    exp_uf = 1'b0;
    uf     = 0;
    y      = W'($urandom);
    if (!is_right) begin
      if (q_l.size() > 0) begin
        s        = q_l.pop_front();
        m_pend_r = q_r.pop_front();
      end else begin
        s        = '0;
        m_pend_r = '0;
        exp_uf   = 1'b1;
      end
      m_active = 1'b1;
    end else begin
      s = m_pend_r;
    end
    act = m_active;
    for (int f = 0; f < n; f++) begin
      @(negedge clk);
      bclk = 1'b0;
      lrck = is_right;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (underflow) uf++;
        if (wr_at_pop && f == 1) begin
          if (k == 2) begin
            check_eq("full_before_pop", {31'd0, write_ready}, 32'd0);
            write = 1'b1; wl = W'($urandom); wr = W'($urandom);
          end else if (k == 3) begin
            check_eq("level_after_pop", {28'd0, fifo_level}, D - 1);
            check_eq("ready_after_pop", {31'd0, write_ready}, 32'd1);
            wl = y; wr = ~y;
          end else if (k == 4) begin
            write = 1'b0;
            q_l.push_back(y);
            q_r.push_back(~y);
            check_eq("level_refill", {28'd0, fifo_level}, D);
          end
        end
      end
      check_eq($sformatf("dac_%s_f%0d", is_right ? "R" : "L", f), {31'd0, dacdat},
               {31'd0, (f == 0) ? m_tail : (act ? bit_at(s, f) : 1'b0)});
      bclk = 1'b1;
      if (rst_at == f) begin
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_dac", {31'd0, dacdat}, 32'd0);
        check_eq("rst_level", {28'd0, fifo_level}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        q_l.delete();
        q_r.delete();
        m_active = 1'b0;
        act      = 1'b0;
      end else begin
        repeat (3) begin
          @(negedge clk);
          if (underflow) uf++;
        end
      end
    end
    m_tail = act ? bit_at(s, n) : 1'b0;
    check_eq(is_right ? "uf_cnt_R" : "uf_cnt_L", uf, {31'd0, exp_uf});
    check_eq("level_half", {28'd0, fifo_level}, q_l.size());
  endtask

  task automatic frame(input int n);
    run_half(1'b0, n, -1, 1'b0);
    run_half(1'b1, n, -1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; bclk = 1'b1; lrck = 1'b0; write = 1'b0; wl = '0; wr = '0;
    repeat (3) @(negedge clk);
    write = 1'b1; wl = 24'h123456; wr = 24'h654321;
    @(negedge clk);
    write = 1'b0;
    @(negedge clk);
    check_eq("rst_level", {28'd0, fifo_level}, 32'd0);
    check_eq("rst_ready", {31'd0, write_ready}, 32'd1);
    check_eq("rst_dac", {31'd0, dacdat}, 32'd0);
    check_eq("rst_uf", {31'd0, underflow}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_level", {28'd0, fifo_level}, 32'd0);

    // Right start while idle: nothing is played.
    run_half(1'b1, 32, -1, 1'b0);

    push(24'h800001, 24'h7FFFFE);
    frame(32);

    for (int i = 1; i <= D; i++) push(W'(i), W'($urandom));
    push(24'h0000AA, 24'h0000BB);

    // Pop with a simultaneous write while full.
    run_half(1'b0, 32, -1, 1'b1);
    run_half(1'b1, 32, -1, 1'b0);
    for (int i = 0; i < D; i++) frame(32);

    frame(32);
    frame(32);

    push(24'hFFFFFF, W'($urandom));
    run_half(1'b0, 32, 10, 1'b0);
    run_half(1'b1, 32, -1, 1'b0);
    push(W'($urandom), W'($urandom));
    frame(32);

    for (int j = 0; j < 6; j++) begin
      int np;
      np = int'($urandom_range(0, 2));
      for (int i = 0; i < np; i++) push(W'($urandom), W'($urandom));
      frame(32);
    end

    for (int j = 0; j < 3; j++) begin
      push(W'($urandom), W'($urandom));
      frame(16);
    end
    frame(32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
